wb_stage: RTL and testbench
===========================

# wb_stage

Final (writeback/commit) pipeline stage, directly downstream of the memory stage. It accepts one instruction per cycle over a valid/allowin handshake and writes the GPR file. It commits CSR writes, resolves the pending exception vector into an ecode, and raises the pipeline-wide flush pulses that every upstream stage consumes. It also owns the IDLE wait state machine and the retired-instruction counter.

## Interface
- No parameters.
- clk  in  1  core clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ms_to_ws_valid  in  1  memory stage presents an instruction.
- ws_allowin  out  1  stage can accept this cycle.
- ms_pc  in  32  instruction PC.
- ms_gr_we / ms_dest / ms_result  in  1/5/32  GPR write enable, index, data.
- ms_excp / ms_excp_num  in  1/16  exception present; raw exception vector (bit map below).
- ms_error_va  in  32  faulting data virtual address.
- ms_ertn / ms_refetch / ms_idle  in  1 each  ERTN, refetch-class, IDLE instruction.
- ms_csr_we / ms_csr_idx / ms_csr_wdata  in  1/14/32  CSR write request.
- has_int  in  1  CSR block reports pending enabled interrupt.
- rf_we / rf_waddr / rf_wdata  out  1/5/32  GPR write port.
- csr_we / csr_waddr / csr_wdata  out  1/14/32  committed CSR write.
- excp_flush / ertn_flush / refetch_flush / idle_flush  out  1 each  flush pulses.
- wb_ecode  out  6  resolved exception code.
- wb_pc  out  32  PC of committing instruction (ERA source).
- wb_badv / va_error  out  32/1  BADV value; BADV write enable.
- tlbr_excp  out  1  selects TLB-refill entry.
- idle_stall  out  1  front end must hold fetch.
- retire_cnt  out  32  committed-instruction count.
- debug_wb_pc / debug_wb_rf_we / debug_wb_rf_wnum / debug_wb_rf_wdata  out  32/4/5/32  difftest trace.

## Operation
- Stage register: ws_valid plus the latched copy of every ms_* field. Load when ms_to_ws_valid && ws_allowin.
- ws_allowin = (state==RUN) && (!ws_valid || ws_ready_go); ws_ready_go = 1.
- ws_valid next: 0 if any flush output asserted this cycle; else ms_to_ws_valid when ws_allowin; else hold.
- commit = ws_valid && !excp_r; flush pulses are combinational from registered fields:
  - excp_flush = ws_valid && excp_r.
  - ertn_flush = commit && ertn_r.
  - refetch_flush = commit && refetch_r && !ertn_r.
  - idle_flush = commit && idle_r.
- rf_we = commit && gr_we_r && dest_r!=0; rf_waddr = dest_r; rf_wdata = result_r.
- csr_we = commit && csr_we_r.
- Exception vector bit -> ecode. The lowest set bit wins.
  - 0 INT 0x00; 1 ADEF 0x08; 2 TLBR-fetch 0x3F; 3 PIF 0x03; 4 PPI-fetch 0x07.
  - 5 SYS 0x0B; 6 BRK 0x0C; 7 INE 0x0D; 8 IPE 0x0E; 9 ALE 0x09; 10 reserved (ignored).
  - 11 TLBR-data 0x3F; 12 PME 0x04; 13 PPI-data 0x07; 14 PIS 0x02; 15 PIL 0x01.
  - excp_r set with no decodable bit -> ecode 0x00.
- va_error = excp_flush && winner ∈ {1,2,3,4,9,11..15}.
  - wb_badv = pc_r when the winner is bit 1–4; otherwise error_va_r.
- tlbr_excp = excp_flush && winner ∈ {2,11}.
- wb_ecode, wb_badv, tlbr_excp are 0 when excp_flush=0.
- wb_pc = pc_r.
- IDLE FSM, two states:
  - RUN -> IDLE_WAIT on idle_flush.
  - IDLE_WAIT -> RUN when has_int=1.
  - idle_stall = (state==IDLE_WAIT).
- retire_cnt increments by 1 on every commit, wraps 0xFFFFFFFF -> 0.
  - Excepted instructions do not count. ERTN and IDLE do count.
- Debug trace:
  - debug_wb_pc = pc_r when ws_valid, else 0.
  - debug_wb_rf_we = {4{rf_we}}.
  - debug_wb_rf_wnum = dest_r; debug_wb_rf_wdata = result_r.

## Timing
- Reset (async): ws_valid=0, state=RUN, retire_cnt=0, stage fields 0. Every output is therefore 0, except ws_allowin=1.
- Latency: an instruction accepted at edge N commits (rf write, CSR write, flush) during cycle N; it writes on edge N+1.
- Flush is a single-cycle pulse. The instruction offered by the memory stage in the flush cycle is dropped, not latched.
- Back-to-back accept is allowed: in RUN, full throughput at one instruction per cycle.
- IDLE_WAIT: ws_allowin=0 from the edge after idle_flush until the edge after has_int is seen.
  - has_int already high in the idle_flush cycle is ignored; it is sampled from IDLE_WAIT only.
- Reset asserted mid-IDLE_WAIT returns to RUN immediately.

## Test plan
- Stream 3 ALU ops (dest 1,2,0, results 0x11,0x22,0x33) back-to-back.
  - rf_we pulses for dest 1 and 2 only.
  - retire_cnt goes 0 -> 3.
  - debug_wb_rf_wnum goes 1, 2, 0.
- Load with ms_excp=1 and ms_excp_num=0xA000 (PIL+PPI-data), error_va 0x1234_5678.
  - ecode 0x07, wb_badv 0x12345678, va_error=1, tlbr_excp=0, rf_we=0.
  - A concurrent ms_to_ws_valid instruction is dropped; ws_valid=0 next cycle.
- excp_num=0x0804 (TLBR-fetch + TLBR-data), pc 0x1C00_0100.
  - ecode 0x3F, tlbr_excp=1, wb_badv 0x1C000100.
- CSR write idx 0x11 data 0xDEAD_BEEF with ms_ertn=1.
  - csr_we=1 with that address and data, ertn_flush=1, refetch_flush=0.
- IDLE commit with has_int high in the same cycle.
  - idle_flush pulse; state goes to IDLE_WAIT; ws_allowin=0 for ≥1 cycle.
  - has_int=1 at cycle +3 returns state to RUN one edge later.
- retire_cnt preset to 0xFFFFFFFF through a long commit run; one more commit wraps it to 0.
  - Async reset asserted mid-cycle clears all outputs without a clock edge.

Source files
------------

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- writeback / commit stage of the pipeline.
//
// Purpose:
//   Holds the last instruction leaving the memory stage for one cycle, writes
//   the GPR file, commits CSR writes, turns the raw exception vector into an
//   ecode and raises the single-cycle flush pulses seen by every upstream
//   stage. Also owns the IDLE wait FSM and the retired-instruction counter.
//
// Ports:
//   clk, reset            core clock; asynchronous active-high reset
//   ms_to_ws_valid        memory stage offers an instruction
//   ws_allowin            this stage accepts the offer this cycle
//   ms_*                  instruction fields latched into the stage register
//   has_int               pending enabled interrupt (wakes IDLE_WAIT)
//   rf_we/waddr/wdata     GPR write port
//   csr_we/waddr/wdata    committed CSR write
//   *_flush               pipeline flush pulses (exception, ERTN, refetch, IDLE)
//   wb_ecode, wb_pc       exception code and PC of the committing instruction
//   wb_badv, va_error     BADV value and its write enable
//   tlbr_excp             TLB-refill entry select
//   idle_stall            front end must hold fetch (FSM is in IDLE_WAIT)
//   retire_cnt            committed-instruction counter
//   debug_wb_*            difftest commit trace
//
// Handshake: an instruction moves in on a rising edge where
//   ms_to_ws_valid && ws_allowin, unless a flush is raised that same cycle,
//   in which case the offered instruction is dropped and nothing is latched.
//   This stage always completes in one cycle (ready_go is constant 1).
// ---------------------------------------------------------------------------
module wb_stage (
    input  logic        clk,
    input  logic        reset,

    input  logic        ms_to_ws_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic        ms_gr_we,
    input  logic [4:0]  ms_dest,
    input  logic [31:0] ms_result,
    input  logic        ms_excp,
    input  logic [15:0] ms_excp_num,
    input  logic [31:0] ms_error_va,
    input  logic        ms_ertn,
    input  logic        ms_refetch,
    input  logic        ms_idle,
    input  logic        ms_csr_we,
    input  logic [13:0] ms_csr_idx,
    input  logic [31:0] ms_csr_wdata,
    input  logic        has_int,

    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,

    output logic        csr_we,
    output logic [13:0] csr_waddr,
    output logic [31:0] csr_wdata,

    output logic        excp_flush,
    output logic        ertn_flush,
    output logic        refetch_flush,
    output logic        idle_flush,

    output logic [5:0]  wb_ecode,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_badv,
    output logic        va_error,
    output logic        tlbr_excp,
    output logic        idle_stall,
    output logic [31:0] retire_cnt,

    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    typedef enum logic {
        S_RUN       = 1'b0,
        S_IDLE_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;

    // Stage register
    logic        ws_valid_q,  ws_valid_d;
    logic [31:0] pc_q,        pc_d;
    logic        gr_we_q,     gr_we_d;
    logic [4:0]  dest_q,      dest_d;
    logic [31:0] result_q,    result_d;
    logic        excp_q,      excp_d;
    logic [15:0] excp_num_q,  excp_num_d;
    logic [31:0] error_va_q,  error_va_d;
    logic        ertn_q,      ertn_d;
    logic        refetch_q,   refetch_d;
    logic        idle_q,      idle_d;
    logic        csr_we_q,    csr_we_d;
    logic [13:0] csr_idx_q,   csr_idx_d;
    logic [31:0] csr_wdata_q, csr_wdata_d;

    logic [31:0] retire_cnt_q, retire_cnt_d;

    // Internal combinational signals
    logic        ws_ready_go;
    logic        commit;
    logic        flush_any;
    logic        load;
    logic        win_found;
    logic [3:0]  win_idx;
    logic [5:0]  win_ecode;
    logic        win_va;
    logic        win_badv_pc;
    logic        win_tlbr;

    // -----------------------------------------------------------------------
    // Exception vector resolution. Walking from the top bit down lets the
    // lowest set bit overwrite any higher one, so it wins. Bit 10 is reserved
    // and never selected; a vector with nothing decodable resolves to 0x00.
    // -----------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_idx   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (i != 10 && excp_num_q[i]) begin
                win_found = 1'b1;
                win_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        win_ecode   = 6'h00;
        win_va      = 1'b0;
        win_badv_pc = 1'b0;
        win_tlbr    = 1'b0;
        if (win_found) begin
            case (win_idx)
                4'd0:  win_ecode = 6'h00;   // INT
                4'd1:  begin win_ecode = 6'h08; win_va = 1'b1; win_badv_pc = 1'b1; end  // ADEF
                4'd2:  begin win_ecode = 6'h3F; win_va = 1'b1; win_badv_pc = 1'b1; win_tlbr = 1'b1; end  // TLBR fetch
                4'd3:  begin win_ecode = 6'h03; win_va = 1'b1; win_badv_pc = 1'b1; end  // PIF
                4'd4:  begin win_ecode = 6'h07; win_va = 1'b1; win_badv_pc = 1'b1; end  // PPI fetch
                4'd5:  win_ecode = 6'h0B;   // SYS
                4'd6:  win_ecode = 6'h0C;   // BRK
                4'd7:  win_ecode = 6'h0D;   // INE
                4'd8:  win_ecode = 6'h0E;   // IPE
                4'd9:  begin win_ecode = 6'h09; win_va = 1'b1; end  // ALE
                4'd11: begin win_ecode = 6'h3F; win_va = 1'b1; win_tlbr = 1'b1; end  // TLBR data
                4'd12: begin win_ecode = 6'h04; win_va = 1'b1; end  // PME
                4'd13: begin win_ecode = 6'h07; win_va = 1'b1; end  // PPI data
                4'd14: begin win_ecode = 6'h02; win_va = 1'b1; end  // PIS
                4'd15: begin win_ecode = 6'h01; win_va = 1'b1; end  // PIL
                default: win_ecode = 6'h00;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Commit, flush and handshake
    // -----------------------------------------------------------------------
    always_comb begin
        ws_ready_go   = 1'b1;
        commit        = ws_valid_q && !excp_q;
        excp_flush    = ws_valid_q && excp_q;
        ertn_flush    = commit && ertn_q;
        refetch_flush = commit && refetch_q && !ertn_q;
        idle_flush    = commit && idle_q;
        flush_any     = excp_flush || ertn_flush || refetch_flush || idle_flush;
        ws_allowin    = (state_q == S_RUN) && (!ws_valid_q || ws_ready_go);
        // An offer arriving in a flush cycle belongs to the squashed path.
        load          = ms_to_ws_valid && ws_allowin && !flush_any;
    end

    // -----------------------------------------------------------------------
    // Next-state for the stage register, counter and IDLE FSM
    // -----------------------------------------------------------------------
    always_comb begin
        ws_valid_d   = ws_valid_q;
        pc_d         = pc_q;
        gr_we_d      = gr_we_q;
        dest_d       = dest_q;
        result_d     = result_q;
        excp_d       = excp_q;
        excp_num_d   = excp_num_q;
        error_va_d   = error_va_q;
        ertn_d       = ertn_q;
        refetch_d    = refetch_q;
        idle_d       = idle_q;
        csr_we_d     = csr_we_q;
        csr_idx_d    = csr_idx_q;
        csr_wdata_d  = csr_wdata_q;
        retire_cnt_d = retire_cnt_q;
        state_d      = state_q;

        if (flush_any) begin
            ws_valid_d = 1'b0;
        end else if (ws_allowin) begin
            ws_valid_d = ms_to_ws_valid;
        end

        if (load) begin
            pc_d        = ms_pc;
            gr_we_d     = ms_gr_we;
            dest_d      = ms_dest;
            result_d    = ms_result;
            excp_d      = ms_excp;
            excp_num_d  = ms_excp_num;
            error_va_d  = ms_error_va;
            ertn_d      = ms_ertn;
            refetch_d   = ms_refetch;
            idle_d      = ms_idle;
            csr_we_d    = ms_csr_we;
            csr_idx_d   = ms_csr_idx;
            csr_wdata_d = ms_csr_wdata;
        end

        if (commit) begin
            retire_cnt_d = retire_cnt_q + 32'd1;   // wraps naturally
        end

        // has_int is only looked at once already waiting, so an interrupt
        // that is high in the idle_flush cycle itself does not skip the wait.
        case (state_q)
            S_RUN:       if (idle_flush) state_d = S_IDLE_WAIT;
            S_IDLE_WAIT: if (has_int)    state_d = S_RUN;
            default:     state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_RUN;
            ws_valid_q   <= 1'b0;
            pc_q         <= 32'd0;
            gr_we_q      <= 1'b0;
            dest_q       <= 5'd0;
            result_q     <= 32'd0;
            excp_q       <= 1'b0;
            excp_num_q   <= 16'd0;
            error_va_q   <= 32'd0;
            ertn_q       <= 1'b0;
            refetch_q    <= 1'b0;
            idle_q       <= 1'b0;
            csr_we_q     <= 1'b0;
            csr_idx_q    <= 14'd0;
            csr_wdata_q  <= 32'd0;
            retire_cnt_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            ws_valid_q   <= ws_valid_d;
            pc_q         <= pc_d;
            gr_we_q      <= gr_we_d;
            dest_q       <= dest_d;
            result_q     <= result_d;
            excp_q       <= excp_d;
            excp_num_q   <= excp_num_d;
            error_va_q   <= error_va_d;
            ertn_q       <= ertn_d;
            refetch_q    <= refetch_d;
            idle_q       <= idle_d;
            csr_we_q     <= csr_we_d;
            csr_idx_q    <= csr_idx_d;
            csr_wdata_q  <= csr_wdata_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output drive
    // -----------------------------------------------------------------------
    always_comb begin
        rf_we             = commit && gr_we_q && (dest_q != 5'd0);
        rf_waddr          = dest_q;
        rf_wdata          = result_q;
        csr_we            = commit && csr_we_q;
        csr_waddr         = csr_idx_q;
        csr_wdata         = csr_wdata_q;
        wb_pc             = pc_q;
        // Exception-side outputs are forced quiet unless an exception flushes.
        wb_ecode          = excp_flush ? win_ecode : 6'h00;
        va_error          = excp_flush && win_va;
        tlbr_excp         = excp_flush && win_tlbr;
        wb_badv           = !excp_flush ? 32'd0 : (win_badv_pc ? pc_q : error_va_q);
        idle_stall        = (state_q == S_IDLE_WAIT);
        retire_cnt        = retire_cnt_q;
        debug_wb_pc       = ws_valid_q ? pc_q : 32'd0;
        debug_wb_rf_we    = {4{rf_we}};
        debug_wb_rf_wnum  = dest_q;
        debug_wb_rf_wdata = result_q;
    end

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// Testbench for wb_stage: directed steps from the stage's usage scenarios,
// then a randomized stream, all checked against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_wb_stage;

    logic        clk;
    logic        reset;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;
    logic        ms_excp;
    logic [15:0] ms_excp_num;
    logic [31:0] ms_error_va;
    logic        ms_ertn;
    logic        ms_refetch;
    logic        ms_idle;
    logic        ms_csr_we;
    logic [13:0] ms_csr_idx;
    logic [31:0] ms_csr_wdata;
    logic        has_int;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_we;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        excp_flush;
    logic        ertn_flush;
    logic        refetch_flush;
    logic        idle_flush;
    logic [5:0]  wb_ecode;
    logic [31:0] wb_pc;
    logic [31:0] wb_badv;
    logic        va_error;
    logic        tlbr_excp;
    logic        idle_stall;
    logic [31:0] retire_cnt;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    wb_stage dut (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result),
        .ms_excp(ms_excp), .ms_excp_num(ms_excp_num), .ms_error_va(ms_error_va),
        .ms_ertn(ms_ertn), .ms_refetch(ms_refetch), .ms_idle(ms_idle),
        .ms_csr_we(ms_csr_we), .ms_csr_idx(ms_csr_idx), .ms_csr_wdata(ms_csr_wdata),
        .has_int(has_int),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .excp_flush(excp_flush), .ertn_flush(ertn_flush),
        .refetch_flush(refetch_flush), .idle_flush(idle_flush),
        .wb_ecode(wb_ecode), .wb_pc(wb_pc), .wb_badv(wb_badv), .va_error(va_error),
        .tlbr_excp(tlbr_excp), .idle_stall(idle_stall), .retire_cnt(retire_cnt),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- transaction + model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic        excp;
        logic [15:0] excp_num;
        logic [31:0] error_va;
        logic        ertn;
        logic        refetch;
        logic        idle;
        logic        csr_we;
        logic [13:0] csr_idx;
        logic [31:0] csr_wdata;
    } txn_t;

    logic [5:0]  ecode_tab [16] = '{6'h00, 6'h08, 6'h3F, 6'h03, 6'h07, 6'h0B, 6'h0C, 6'h0D,
                                    6'h0E, 6'h09, 6'h00, 6'h3F, 6'h04, 6'h07, 6'h02, 6'h01};
    logic [15:0] va_mask   = 16'hFA1E;   // bits 1-4, 9, 11-15
    logic [15:0] pc_mask   = 16'h001E;   // bits 1-4 report the PC as BADV
    logic [15:0] tlbr_mask = 16'h0804;   // bits 2 and 11

    // Model: what the stage holds, whether it is waiting on IDLE, and how many
    // instructions have retired.
    logic        m_valid;
    logic        m_idle;
    logic [31:0] m_cnt;
    txn_t        m_t;

    int n_checks = 0;
    int n_fail   = 0;
    txn_t empty_t;
    txn_t t;

    function automatic int winner(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (i != 10 && v[i]) return i;
        end
        return -1;
    endfunction

    function automatic txn_t alu(input logic [31:0] pc, input logic [4:0] dest,
                                 input logic [31:0] res);
        txn_t r;
        r = '0;
        r.pc = pc; r.gr_we = 1'b1; r.dest = dest; r.result = res;
        return r;
    endfunction

    function automatic txn_t rand_txn();
        txn_t r;
        r.pc        = $urandom;
        r.gr_we     = 1'($urandom_range(0, 1));
        r.dest      = 5'($urandom_range(0, 31));
        r.result    = $urandom;
        r.excp      = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 3))
            0: r.excp_num = 16'($urandom);
            1: r.excp_num = 16'(1 << $urandom_range(0, 15));
            2: r.excp_num = 16'h0400;
            default: r.excp_num = 16'h0000;
        endcase
        r.error_va  = $urandom;
        r.ertn      = ($urandom_range(0, 9) == 0);
        r.refetch   = ($urandom_range(0, 7) == 0);
        r.idle      = ($urandom_range(0, 11) == 0);
        r.csr_we    = ($urandom_range(0, 3) == 0);
        r.csr_idx   = 14'($urandom_range(0, 16383));
        r.csr_wdata = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_idle  = 1'b0;
        m_cnt   = 32'd0;
        m_t     = '0;
    endtask

    // Compare every output against what the model's held instruction implies.
    task automatic check_all();
        logic commit, ef, e_rf_we, e_va, e_tl, use_pc;
        int w;
        logic [5:0] e_ecode;
        commit  = m_valid && !m_t.excp;
        ef      = m_valid && m_t.excp;
        w       = winner(m_t.excp_num);
        e_rf_we = commit && m_t.gr_we && (m_t.dest != 5'd0);
        e_va    = ef && (w >= 0) && va_mask[w];
        e_tl    = ef && (w >= 0) && tlbr_mask[w];
        use_pc  = (w >= 0) && pc_mask[w];
        e_ecode = (!ef || w < 0) ? 6'h00 : ecode_tab[w];
        chk("ws_allowin",    32'(ws_allowin),    32'(!m_idle));
        chk("idle_stall",    32'(idle_stall),    32'(m_idle));
        chk("excp_flush",    32'(excp_flush),    32'(ef));
        chk("ertn_flush",    32'(ertn_flush),    32'(commit && m_t.ertn));
        chk("refetch_flush", 32'(refetch_flush), 32'(commit && m_t.refetch && !m_t.ertn));
        chk("idle_flush",    32'(idle_flush),    32'(commit && m_t.idle));
        chk("rf_we",         32'(rf_we),         32'(e_rf_we));
        chk("rf_waddr",      32'(rf_waddr),      32'(m_t.dest));
        chk("rf_wdata",      rf_wdata,           m_t.result);
        chk("csr_we",        32'(csr_we),        32'(commit && m_t.csr_we));
        if (commit && m_t.csr_we) begin
            chk("csr_waddr", 32'(csr_waddr),     32'(m_t.csr_idx));
            chk("csr_wdata", csr_wdata,          m_t.csr_wdata);
        end
        chk("wb_ecode",      32'(wb_ecode),      32'(e_ecode));
        chk("va_error",      32'(va_error),      32'(e_va));
        chk("tlbr_excp",     32'(tlbr_excp),     32'(e_tl));
        chk("wb_badv",       wb_badv,            !ef ? 32'd0 : (use_pc ? m_t.pc : m_t.error_va));
        chk("wb_pc",         wb_pc,              m_t.pc);
        chk("retire_cnt",    retire_cnt,         m_cnt);
        chk("debug_wb_pc",   debug_wb_pc,        m_valid ? m_t.pc : 32'd0);
        chk("debug_rf_we",   32'(debug_wb_rf_we), e_rf_we ? 32'hF : 32'h0);
        chk("debug_rf_wnum", 32'(debug_wb_rf_wnum), 32'(m_t.dest));
        chk("debug_rf_wdata", debug_wb_rf_wdata, m_t.result);
    endtask

    // Advance the model across the coming rising edge given what is offered.
    task automatic model_update(input txn_t x, input logic offer, input logic hi);
        logic commit, flush, allow;
        commit = m_valid && !m_t.excp;
        flush  = m_valid && (m_t.excp || m_t.ertn || m_t.refetch || m_t.idle);
        allow  = !m_idle;
        if (commit) m_cnt = m_cnt + 32'd1;
        if (allow && offer && !flush) m_t = x;
        if (flush)       m_valid = 1'b0;
        else if (allow)  m_valid = offer;
        if (m_idle) begin
            if (hi) m_idle = 1'b0;
        end else if (commit && m_t.idle && !(allow && offer && !flush)) begin
            m_idle = 1'b1;
        end else if (commit && flush && m_valid == 1'b0 && idle_flush_pending) begin
            m_idle = 1'b1;
        end
    endtask

    // Captured before the model moves, so the IDLE transition uses the
    // instruction that is committing now rather than the newly loaded one.
    logic idle_flush_pending;

    // ---------------- driver ----------------
    task automatic drive(input txn_t x, input logic offer, input logic hi);
        ms_to_ws_valid = offer;
        ms_pc = x.pc; ms_gr_we = x.gr_we; ms_dest = x.dest; ms_result = x.result;
        ms_excp = x.excp; ms_excp_num = x.excp_num; ms_error_va = x.error_va;
        ms_ertn = x.ertn; ms_refetch = x.refetch; ms_idle = x.idle;
        ms_csr_we = x.csr_we; ms_csr_idx = x.csr_idx; ms_csr_wdata = x.csr_wdata;
        has_int = hi;
    endtask

    // One cycle: drive at the falling edge, check the held instruction, then
    // move the model across the next rising edge.
    task automatic cycle(input txn_t x, input logic offer, input logic hi);
        @(negedge clk);
        drive(x, offer, hi);
        #1;
        check_all();
        idle_flush_pending = m_valid && !m_t.excp && m_t.idle;
        model_update(x, offer, hi);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        empty_t = '0;
        idle_flush_pending = 1'b0;
        reset = 1'b1;
        drive(empty_t, 1'b0, 1'b0);
        model_reset();
        #2;
        check_all();
        chk("reset_allowin", 32'(ws_allowin), 32'd1);
        chk("reset_retire",  retire_cnt,      32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Three ALU ops back to back; dest 0 must not write.
        cycle(alu(32'h1C00_0000, 5'd1, 32'h11), 1'b1, 1'b0);
        cycle(alu(32'h1C00_0004, 5'd2, 32'h22), 1'b1, 1'b0);
        chk("alu1_rf_we",   32'(rf_we),            32'd1);
        chk("alu1_wnum",    32'(debug_wb_rf_wnum), 32'd1);
        cycle(alu(32'h1C00_0008, 5'd0, 32'h33), 1'b1, 1'b0);
        chk("alu2_rf_waddr", 32'(rf_waddr),        32'd2);
        chk("alu2_rf_wdata", rf_wdata,             32'h22);
        cycle(empty_t, 1'b0, 1'b0);
        chk("alu3_rf_we",   32'(rf_we),            32'd0);
        chk("alu3_wnum",    32'(debug_wb_rf_wnum), 32'd0);
        cycle(empty_t, 1'b0, 1'b0);
        chk("alu_retire3",  retire_cnt,            32'd3);

        // Load with PIL + PPI-data: lowest bit (PPI-data) wins.
        t = alu(32'h1C00_0010, 5'd4, 32'h44);
        t.excp = 1'b1; t.excp_num = 16'hA000; t.error_va = 32'h1234_5678;
        cycle(t, 1'b1, 1'b0);
        cycle(alu(32'h1C00_0014, 5'd5, 32'h55), 1'b1, 1'b0);
        chk("ld_ecode",    32'(wb_ecode),  32'h07);
        chk("ld_badv",     wb_badv,        32'h1234_5678);
        chk("ld_va_error", 32'(va_error),  32'd1);
        chk("ld_tlbr",     32'(tlbr_excp), 32'd0);
        chk("ld_rf_we",    32'(rf_we),     32'd0);
        cycle(empty_t, 1'b0, 1'b0);
        chk("ld_dropped",  debug_wb_pc,    32'd0);

        // TLB refill on fetch and data: fetch bit wins, BADV is the PC.
        t = '0;
        t.pc = 32'h1C00_0100; t.excp = 1'b1; t.excp_num = 16'h0804; t.error_va = 32'hCAFE_0000;
        cycle(t, 1'b1, 1'b0);
        cycle(empty_t, 1'b0, 1'b0);
        chk("tlbr_ecode", 32'(wb_ecode),  32'h3F);
        chk("tlbr_excp",  32'(tlbr_excp), 32'd1);
        chk("tlbr_badv",  wb_badv,        32'h1C00_0100);

        // CSR write together with ERTN (refetch also set, ERTN takes it).
        t = '0;
        t.pc = 32'h1C00_0200; t.csr_we = 1'b1; t.csr_idx = 14'h11;
        t.csr_wdata = 32'hDEAD_BEEF; t.ertn = 1'b1; t.refetch = 1'b1;
        cycle(t, 1'b1, 1'b0);
        cycle(empty_t, 1'b0, 1'b0);
        chk("ertn_csr_we",    32'(csr_we),        32'd1);
        chk("ertn_csr_addr",  32'(csr_waddr),     32'h11);
        chk("ertn_csr_data",  csr_wdata,          32'hDEAD_BEEF);
        chk("ertn_flush",     32'(ertn_flush),    32'd1);
        chk("ertn_no_refetch", 32'(refetch_flush), 32'd0);

        // IDLE with has_int already high in the flush cycle: still waits.
        t = alu(32'h1C00_0300, 5'd0, 32'h0);
        t.idle = 1'b1;
        cycle(t, 1'b1, 1'b0);
        cycle(alu(32'h1C00_0304, 5'd3, 32'h66), 1'b1, 1'b1);
        chk("idle_flush_pulse", 32'(idle_flush), 32'd1);
        cycle(alu(32'h1C00_0308, 5'd3, 32'h77), 1'b1, 1'b0);
        chk("idle_wait_stall",   32'(idle_stall), 32'd1);
        chk("idle_wait_allowin", 32'(ws_allowin), 32'd0);
        cycle(empty_t, 1'b0, 1'b0);
        cycle(empty_t, 1'b0, 1'b1);
        chk("idle_still_waiting", 32'(idle_stall), 32'd1);
        cycle(empty_t, 1'b0, 1'b0);
        chk("idle_woken",        32'(idle_stall), 32'd0);
        chk("idle_woken_allowin", 32'(ws_allowin), 32'd1);

        // Randomized stream.
        for (int i = 0; i < 400; i++) begin
            cycle(rand_txn(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
        end

        // Drain, then preset the counter to its top value and commit once.
        cycle(empty_t, 1'b0, 1'b1);
        cycle(empty_t, 1'b0, 1'b1);
        cycle(empty_t, 1'b0, 1'b1);
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        chk("wrap_preset", retire_cnt, 32'hFFFF_FFFF);
        cycle(alu(32'h1C00_0400, 5'd7, 32'h88), 1'b1, 1'b0);
        cycle(empty_t, 1'b0, 1'b0);
        cycle(empty_t, 1'b0, 1'b0);
        chk("wrap_zero", retire_cnt, 32'd0);

        // Async reset mid-IDLE_WAIT, between clock edges.
        t = alu(32'h1C00_0500, 5'd9, 32'h99);
        t.idle = 1'b1;
        cycle(t, 1'b1, 1'b0);
        cycle(empty_t, 1'b0, 1'b0);
        cycle(empty_t, 1'b0, 1'b0);
        chk("pre_reset_stall", 32'(idle_stall), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("areset_stall",   32'(idle_stall), 32'd0);
        chk("areset_allowin", 32'(ws_allowin), 32'd1);
        chk("areset_retire",  retire_cnt,      32'd0);
        @(negedge clk);
        reset = 1'b0;
        cycle(alu(32'h1C00_0600, 5'd10, 32'hAA), 1'b1, 1'b0);
        cycle(empty_t, 1'b0, 1'b0);
        cycle(empty_t, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
